mux_exerciser: RTL and testbench

Self-checking stimulus/response stage for the 2-to-1 multiplexer built from the 7404/7408/7432 chip models. It sits directly upstream of the mux and drives its `x`, `y` and `s` inputs. It also sits directly downstream of it, sampling `m`. After a start pulse it steps through all eight input combinations, gives the mux a programmable settle time per combination, and checks `m` against the expected value. It reports a done flag, a sticky error flag and an error count.

---
 rtl/mux_exerciser.sv | 104 ++++++++++
 tb/tb_mux_exerciser.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_exerciser.sv
// Stimulus/response checker for the gate-level 2-to-1 mux: sweeps all eight
// {s,y,x} combinations, waits DIV cycles per combination, then compares m.
module mux_exerciser #(
  parameter int unsigned DIV    = 4,
  parameter int unsigned PASSES = 1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       m,
  output logic       x,
  output logic       y,
  output logic       s,
  output logic [2:0] pattern,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] err_count
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] TICK_LAST = 8'(DIV - 1);
  localparam logic [3:0] PASS_LAST = 4'(PASSES - 1);

  state_t     state, state_n;
  logic [7:0] tick, tick_n;
  logic [3:0] pass, pass_n;
  logic [2:0] pattern_n;
  logic [3:0] err_count_n;
  logic       err_n;
  logic       expected;

  assign s        = pattern[2];
  assign y        = pattern[1];
  assign x        = pattern[0];
  assign expected = s ? y : x;

  always_comb begin
    state_n     = state;
    tick_n      = tick;
    pass_n      = pass;
    pattern_n   = pattern;
    err_count_n = err_count;
    err_n       = err;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n     = SETTLE;
          tick_n      = '0;
          pass_n      = '0;
          pattern_n   = '0;
          err_count_n = '0;
          err_n       = 1'b0;
        end
      end
      SETTLE: begin
        if (tick == TICK_LAST) state_n = CHECK;
        else                   tick_n  = tick + 8'd1;
      end
      CHECK: begin
        if (m != expected) begin
          err_n = 1'b1;
          if (err_count != 4'hF) err_count_n = err_count + 4'd1;
        end
        tick_n = '0;
        if (pattern != 3'd7) begin
          pattern_n = pattern + 3'd1;
          state_n   = SETTLE;
        end else if (pass != PASS_LAST) begin
          pattern_n = '0;
          pass_n    = pass + 4'd1;
          state_n   = SETTLE;
        end else begin
          state_n = DONE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      tick      <= '0;
      pass      <= '0;
      pattern   <= '0;
      err_count <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      tick      <= tick_n;
      pass      <= pass_n;
      pattern   <= pattern_n;
      err_count <= err_count_n;
      err       <= err_n;
    end
  end

  // busy/done are pure state decodes so they can never disagree with the FSM
  assign busy = (state == SETTLE) || (state == CHECK);
  assign done = (state == DONE);

endmodule

// File: tb/tb_mux_exerciser.sv
// Bench for mux_exerciser: several parameterisations, each with its own mux model on m,
// checked against a schedule-level model of when each combination is sampled.
module tb_mux_exerciser;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_v [N];
  logic       m_v     [N];
  logic       x_v     [N];
  logic       y_v     [N];
  logic       s_v     [N];
  logic [2:0] pat_v   [N];
  logic       busy_v  [N];
  logic       done_v  [N];
  logic       err_v   [N];
  logic [3:0] ec_v    [N];
  logic       flip5;
  logic [2:0] d3 = '0;
  logic [2:0] d4 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_exerciser #(.DIV(4), .PASSES(1)) u0 (.clk(clk), .resetn(resetn), .start(start_v[0]), .m(m_v[0]),
    .x(x_v[0]), .y(y_v[0]), .s(s_v[0]), .pattern(pat_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .err(err_v[0]), .err_count(ec_v[0]));
  mux_exerciser #(.DIV(2), .PASSES(1)) u1 (.clk(clk), .resetn(resetn), .start(start_v[1]), .m(m_v[1]),
    .x(x_v[1]), .y(y_v[1]), .s(s_v[1]), .pattern(pat_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .err(err_v[1]), .err_count(ec_v[1]));
  mux_exerciser #(.DIV(1), .PASSES(2)) u2 (.clk(clk), .resetn(resetn), .start(start_v[2]), .m(m_v[2]),
    .x(x_v[2]), .y(y_v[2]), .s(s_v[2]), .pattern(pat_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .err(err_v[2]), .err_count(ec_v[2]));
  mux_exerciser #(.DIV(3), .PASSES(1)) u3 (.clk(clk), .resetn(resetn), .start(start_v[3]), .m(m_v[3]),
    .x(x_v[3]), .y(y_v[3]), .s(s_v[3]), .pattern(pat_v[3]), .busy(busy_v[3]), .done(done_v[3]),
    .err(err_v[3]), .err_count(ec_v[3]));
  mux_exerciser #(.DIV(2), .PASSES(1)) u4 (.clk(clk), .resetn(resetn), .start(start_v[4]), .m(m_v[4]),
    .x(x_v[4]), .y(y_v[4]), .s(s_v[4]), .pattern(pat_v[4]), .busy(busy_v[4]), .done(done_v[4]),
    .err(err_v[4]), .err_count(ec_v[4]));
  mux_exerciser #(.DIV(1), .PASSES(3)) u5 (.clk(clk), .resetn(resetn), .start(start_v[5]), .m(m_v[5]),
    .x(x_v[5]), .y(y_v[5]), .s(s_v[5]), .pattern(pat_v[5]), .busy(busy_v[5]), .done(done_v[5]),
    .err(err_v[5]), .err_count(ec_v[5]));

  // Mux models: correct, stuck low, inverted, registered (output flop plus two-stage line), random faults
  assign m_v[0] = s_v[0] ? y_v[0] : x_v[0];
  assign m_v[1] = 1'b0;
  assign m_v[2] = ~(s_v[2] ? y_v[2] : x_v[2]);
  assign m_v[3] = d3[2];
  assign m_v[4] = d4[2];
  assign m_v[5] = (s_v[5] ? y_v[5] : x_v[5]) ^ flip5;

  always @(posedge clk) begin
    d3 <= {d3[1:0], (s_v[3] ? y_v[3] : x_v[3])};
    d4 <= {d4[1:0], (s_v[4] ? y_v[4] : x_v[4])};
  end

  function automatic bit mux_of(input int p);
    return ((p >> 2) & 1) != 0 ? (((p >> 1) & 1) != 0) : ((p & 1) != 0);
  endfunction

  // Cycle t counts from the first cycle after the start edge; combination k of the run
  // is shown for cycles k*(div+1)..k*(div+1)+div and m is judged in the last of them.
  function automatic int pat_at(input int t, input int div);
    return (t < 0) ? 0 : (t / (div + 1)) % 8;
  endfunction

  // kind: 0 correct, 1 stuck low, 2 inverted, 3 m lags the mux inputs by 3 cycles
  function automatic int exp_errs(input int kind, input int div, input int passes);
    int n = 0;
    for (int k = 0; k < 8 * passes; k++) begin
      int  tc  = k * (div + 1) + div;
      int  p   = k % 8;
      bit  obs;
      case (kind)
        0:       obs = mux_of(p);
        1:       obs = 1'b0;
        2:       obs = !mux_of(p);
        default: obs = mux_of(pat_at(tc - 3, div));
      endcase
      if (obs != mux_of(p)) n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  // Pulse start on instance k and follow the run until busy drops; no comparisons here.
  task automatic do_run(input int k, input int div, input int repulse,
                        output int cyc, output int pat_bad, output logic [9:0] snap);
    @(posedge clk); #1;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    cyc = 0;
    pat_bad = 0;
    snap = {busy_v[k], done_v[k], err_v[k], ec_v[k], pat_v[k]};
    while (busy_v[k] === 1'b1 && cyc < 2000) begin
      if (pat_v[k] !== 3'(pat_at(cyc, div))) pat_bad++;
      if ({s_v[k], y_v[k], x_v[k]} !== pat_v[k]) pat_bad++;
      start_v[k] = (cyc == repulse);
      @(posedge clk); #1;
      cyc++;
    end
    start_v[k] = 1'b0;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 5)) @(posedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) begin
      checks++;
      if ({x_v[k], y_v[k], s_v[k], pat_v[k], busy_v[k], done_v[k], err_v[k], ec_v[k]} !== 13'd0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got %b, want all zero", k,
          {x_v[k], y_v[k], s_v[k], pat_v[k], busy_v[k], done_v[k], err_v[k], ec_v[k]});
      end
    end
    resetn = 1'b1;
  endtask

  task automatic test_correct_mux();
    int cyc, bad; logic [9:0] snap;
    idle_gap();
    do_run(0, 4, -1, cyc, bad, snap);
    checks++; if (cyc != 40) begin errors++; $display("FAIL correct_busy_len: got %0d, want 40", cyc); end
    checks++; if (bad != 0) begin errors++; $display("FAIL correct_pattern_seq: got %0d bad cycles, want 0", bad); end
    checks++; if (snap[9:7] !== 3'b100) begin errors++; $display("FAIL correct_first_cycle busy/done/err: got %b, want 100", snap[9:7]); end
    checks++; if ({done_v[0], err_v[0]} !== 2'b10) begin errors++; $display("FAIL correct_done_err: got %b, want 10", {done_v[0], err_v[0]}); end
    checks++; if (ec_v[0] !== 4'(exp_errs(0, 4, 1))) begin errors++; $display("FAIL correct_err_count: got %0d, want %0d", ec_v[0], exp_errs(0, 4, 1)); end
    repeat (3) @(posedge clk); #1;
    checks++; if ({busy_v[0], done_v[0]} !== 2'b01) begin errors++; $display("FAIL correct_done_held: got %b, want 01", {busy_v[0], done_v[0]}); end
  endtask

  task automatic test_stuck_low();
    int cyc, bad; logic [9:0] snap;
    idle_gap();
    do_run(1, 2, -1, cyc, bad, snap);
    checks++; if (cyc != 24) begin errors++; $display("FAIL stuck_busy_len: got %0d, want 24", cyc); end
    checks++; if (bad != 0) begin errors++; $display("FAIL stuck_pattern_seq: got %0d bad cycles, want 0", bad); end
    checks++; if (ec_v[1] !== 4'(exp_errs(1, 2, 1))) begin errors++; $display("FAIL stuck_err_count: got %0d, want %0d", ec_v[1], exp_errs(1, 2, 1)); end
    checks++; if ({done_v[1], err_v[1]} !== 2'b11) begin errors++; $display("FAIL stuck_done_err: got %b, want 11", {done_v[1], err_v[1]}); end
  endtask

  task automatic test_saturation();
    int cyc, bad; logic [9:0] snap;
    idle_gap();
    do_run(2, 1, -1, cyc, bad, snap);
    checks++; if (cyc != 32) begin errors++; $display("FAIL sat_busy_len: got %0d, want 32", cyc); end
    checks++; if (bad != 0) begin errors++; $display("FAIL sat_pattern_seq: got %0d bad cycles, want 0", bad); end
    checks++; if (ec_v[2] !== 4'(exp_errs(2, 1, 2))) begin errors++; $display("FAIL sat_err_count: got %0d, want %0d", ec_v[2], exp_errs(2, 1, 2)); end
    checks++; if (err_v[2] !== 1'b1) begin errors++; $display("FAIL sat_err: got %b, want 1", err_v[2]); end
  endtask

  task automatic test_ignored_start();
    int cyc, bad; logic [9:0] snap;
    int r;
    idle_gap();
    // cycle 9 is the first SETTLE cycle of combination 3 at DIV=2
    do_run(1, 2, 9, cyc, bad, snap);
    checks++; if (cyc != 24 || bad != 0) begin errors++; $display("FAIL ignore_start_p3: got len %0d bad %0d, want 24 0", cyc, bad); end
    r = $urandom_range(1, 22);
    do_run(1, 2, r, cyc, bad, snap);
    checks++; if (cyc != 24 || bad != 0) begin errors++; $display("FAIL ignore_start_rand@%0d: got len %0d bad %0d, want 24 0", r, cyc, bad); end
    checks++; if (ec_v[1] !== 4'(exp_errs(1, 2, 1))) begin errors++; $display("FAIL ignore_err_count: got %0d, want %0d", ec_v[1], exp_errs(1, 2, 1)); end
  endtask

  task automatic test_restart();
    int cyc, bad; logic [9:0] snap;
    // instance 1 sits in DONE with a count of 4 from the previous run
    do_run(1, 2, -1, cyc, bad, snap);
    checks++; if (snap !== 10'b1_0_0_0000_000) begin errors++; $display("FAIL restart_clear: got %b, want 1000000000", snap); end
    checks++; if (cyc != 24 || ec_v[1] !== 4'd4) begin errors++; $display("FAIL restart_run: got len %0d count %0d, want 24 4", cyc, ec_v[1]); end
  endtask

  task automatic test_reset_midrun();
    int cyc, bad, n; logic [9:0] snap;
    idle_gap();
    @(posedge clk); #1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    n = 0;
    while (pat_v[0] !== 3'd5 && n < 100) begin @(posedge clk); #1; n++; end
    checks++; if (n != 25) begin errors++; $display("FAIL reach_pattern5: got %0d cycles, want 25", n); end
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    checks++;
    if ({x_v[0], y_v[0], s_v[0], pat_v[0], busy_v[0], done_v[0], err_v[0], ec_v[0]} !== 13'd0) begin
      errors++;
      $display("FAIL midrun_reset_outputs: got %b, want all zero",
        {x_v[0], y_v[0], s_v[0], pat_v[0], busy_v[0], done_v[0], err_v[0], ec_v[0]});
    end
    repeat (3) @(posedge clk); #1;
    checks++; if ({busy_v[0], done_v[0], pat_v[0]} !== 5'd0) begin errors++; $display("FAIL midrun_stays_idle: got %b, want 00000", {busy_v[0], done_v[0], pat_v[0]}); end
    do_run(0, 4, -1, cyc, bad, snap);
    checks++; if (cyc != 40 || bad != 0 || ec_v[0] !== 4'd0 || done_v[0] !== 1'b1) begin
      errors++; $display("FAIL after_reset_run: got len %0d bad %0d count %0d done %b, want 40 0 0 1", cyc, bad, ec_v[0], done_v[0]);
    end
  endtask

  task automatic test_delayed_mux();
    int cyc, bad; logic [9:0] snap;
    do_run(3, 3, -1, cyc, bad, snap);
    checks++; if (cyc != 32 || ec_v[3] !== 4'(exp_errs(3, 3, 1))) begin
      errors++; $display("FAIL delay_div3: got len %0d count %0d, want 32 %0d", cyc, ec_v[3], exp_errs(3, 3, 1));
    end
    do_run(4, 2, -1, cyc, bad, snap);
    checks++; if (cyc != 24 || ec_v[4] !== 4'(exp_errs(3, 2, 1))) begin
      errors++; $display("FAIL delay_div2: got len %0d count %0d, want 24 %0d", cyc, ec_v[4], exp_errs(3, 2, 1));
    end
    checks++; if (ec_v[4] === 4'd0 || err_v[4] !== 1'b1) begin errors++; $display("FAIL delay_div2_flagged: got count %0d err %b, want nonzero 1", ec_v[4], err_v[4]); end
  endtask

  task automatic test_random_faults();
    bit flips [64];
    int cyc, n;
    for (int rep = 0; rep < 4; rep++) begin
      idle_gap();
      @(posedge clk); #1;
      start_v[5] = 1'b1;
      @(posedge clk); #1;
      start_v[5] = 1'b0;
      cyc = 0;
      while (busy_v[5] === 1'b1 && cyc < 64) begin
        flips[cyc] = 1'($urandom_range(0, 1));
        flip5 = flips[cyc];
        @(posedge clk); #1;
        cyc++;
      end
      flip5 = 1'b0;
      n = 0;
      for (int k = 0; k < 24; k++) if (flips[k * 2 + 1]) n++;
      if (n > 15) n = 15;
      checks++;
      if (cyc != 48 || ec_v[5] !== 4'(n) || err_v[5] !== (n != 0)) begin
        errors++; $display("FAIL random_faults rep%0d: got len %0d count %0d err %b, want 48 %0d %b", rep, cyc, ec_v[5], err_v[5], n, n != 0);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) start_v[k] = 1'b0;
    flip5 = 1'b0;
    test_reset();
    test_correct_mux();
    test_stuck_low();
    test_saturation();
    test_ignored_start();
    test_restart();
    test_reset_midrun();
    test_delayed_mux();
    test_random_faults();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
